keys_debounce: RTL and testbench
================================

// Module: keys_debounce
// PURPOSE
//  Conditions the raw board push-buttons before they reach a game/test core on the VGA
//  wrappers (the keys[3:0] path).
//  Per key: 2-FF synchroniser, debounce FSM, registered level, 1-cycle press/release
//  strobes and optional auto-repeat strobes.
//  Runs on the undivided board clock. Strobes are 1 clk wide; a core clocked at clk/2
//  must use the level outputs or stretch the strobes.
// PARAMETERS
//  N_KEYS        4      number of independent key channels
//  ACTIVE_LOW    1      1: raw key pressed = 0; 0: raw key pressed = 1
//  DEB_CYCLES    50000  consecutive stable clk cycles needed to accept a change (>=1)
//  CNT_W         16     debounce counter width; DEB_CYCLES-1 must fit in CNT_W
//  REPEAT_DELAY  0      cycles from press strobe to first repeat strobe; 0 disables repeat
//  REPEAT_PERIOD 1      cycles between subsequent repeat strobes (>=1)
//  RPT_W         24     repeat counter width; max(REPEAT_DELAY,REPEAT_PERIOD)-1 must fit
// PORTS
//  clk          in   1       system clock
//  reset        in   1       asynchronous, active-high
//  keys_in      in   N_KEYS  raw asynchronous button inputs
//  keys_level   out  N_KEYS  debounced state, 1 = pressed (polarity normalised)
//  keys_press   out  N_KEYS  1-clk strobe on accepted press
//  keys_release out  N_KEYS  1-clk strobe on accepted release
//  keys_repeat  out  N_KEYS  1-clk auto-repeat strobe while held
//  keys_any     out  1       OR of keys_level
// BEHAVIOUR
//  - Reset (async, clk, reset): sync FFs reset to the released raw level. All FSMs go to
//    UP. Counters reset to 0. All outputs reset to 0. No strobe is generated by reset or
//    by its release.
//  - s = sync2 ^ ACTIVE_LOW, giving 1 = pressed. Channels are fully independent; no
//    cross-key priority.
//  - FSM per key: UP, CHK_DN, DOWN, CHK_UP. cnt is cleared on every state change.
//    - UP:     s=1 -> CHK_DN.
//    - CHK_DN: s=0 -> UP (bounce, no strobe). s=1 and cnt==DEB_CYCLES-1 -> DOWN, with
//      level<=1 and press<=1. Otherwise cnt++.
//    - DOWN:   s=0 -> CHK_UP.
//    - CHK_UP: s=1 -> DOWN (bounce, no strobe). s=0 and cnt==DEB_CYCLES-1 -> UP, with
//      level<=0 and release<=1. Otherwise cnt++.
//  - Latency: raw input sampled new at clk edge E and held stable -> press/release
//    registered high after edge E+DEB_CYCLES+2, for exactly one cycle.
//  - keys_level changes on the same edge as its strobe. keys_any is combinational OR of
//    the registered levels.
//  - Auto-repeat (REPEAT_DELAY>0):
//    - On CHK_DN->DOWN: r=0, first=1.
//    - In DOWN, each edge: thr = first ? REPEAT_DELAY : REPEAT_PERIOD. If r==thr-1 then
//      repeat<=1, r<=0, first<=0; else r++.
//    - In CHK_UP, r and first hold and no repeat strobe is issued. Bounce back to DOWN
//      resumes counting; it does not restart.
//    - First repeat is registered after edge P+REPEAT_DELAY (P = press edge), then every
//      REPEAT_PERIOD edges.
//    - repeat never coincides with press or release.
//  - Counters never wrap: parameter limits guarantee cnt<DEB_CYCLES and r<thr.
//  - Reset mid-debounce or mid-hold aborts immediately. The key reads released and no
//    release strobe is issued.
// TESTING (N_KEYS=4, ACTIVE_LOW=1, DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1. Reset with keys_in=4'hF, then release reset.
//     -> all outputs 0 for 20 cycles, no strobes.
//  2. keys_in[0]=0, sampled at edge E, held.
//     -> keys_press[0]=1 only in the cycle after edge E+6.
//     -> keys_level[0]=1 and keys_any=1 from then on.
//  3. Bounce keys_in[1]: low 3 cycles, high 1, low 3, high.
//     -> no press, no level change.
//     Then hold low 10 cycles -> exactly one keys_press[1].
//  4. Hold key 2 after press edge P.
//     -> keys_repeat[2] after edges P+10, P+13, P+16 while held.
//     -> release gives keys_release[2] one cycle wide after DEB_CYCLES+2 edges, and no
//        further repeats.
//  5. Keys 0 and 3 pressed on the same edge.
//     -> both press strobes in the same cycle, independent levels.
//     A 2-cycle release glitch on key 3 while held -> no release, repeat cadence unchanged.
//  6. Assert reset while key 0 is held and level=1.
//     -> level drops asynchronously, no release strobe.
//     Release reset with key still low -> new press strobe 6 edges later.

Source files
------------

// File: rtl/keys_debounce.sv
// ----------------------------------------------------------------------------
// keys_debounce : per-key synchroniser, debounce FSM, level, press/release/repeat
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module keys_debounce #(
  parameter int N_KEYS        = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int DEB_CYCLES    = 50000,
  parameter int CNT_W         = 16,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 1,
  parameter int RPT_W         = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] keys_in,
  output logic [N_KEYS-1:0] keys_level,
  output logic [N_KEYS-1:0] keys_press,
  output logic [N_KEYS-1:0] keys_release,
  output logic [N_KEYS-1:0] keys_repeat,
  output logic              keys_any
);

  // Raw level of a released key; XOR with it normalises to 1 = pressed.
  localparam logic [N_KEYS-1:0] c_RAW_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [CNT_W-1:0]  c_DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam bit                c_RPT_EN   = (REPEAT_DELAY > 0);
  localparam logic [RPT_W-1:0]  c_DLY_LAST = RPT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RPT_W-1:0]  c_PER_LAST = RPT_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  typedef enum logic [1:0] {
    ST_UP     = 2'd0,
    ST_CHK_DN = 2'd1,
    ST_DOWN   = 2'd2,
    ST_CHK_UP = 2'd3
  } key_state_e;

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= c_RAW_IDLE;
      sync2_q <= c_RAW_IDLE;
    end else begin
      sync1_q <= keys_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             first_q, first_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;
    logic             key_s;
    logic [RPT_W-1:0] rpt_thr_last;

    assign key_s        = sync2_q[k] ^ c_RAW_IDLE[k];
    assign rpt_thr_last = first_q ? c_DLY_LAST : c_PER_LAST;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q   <= ST_UP;
        cnt_q     <= '0;
        rpt_q     <= '0;
        first_q   <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        rpt_q     <= rpt_d;
        first_q   <= first_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        repeat_q  <= repeat_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rpt_d     = rpt_q;
      first_d   = first_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;

      case (state_q)
        ST_UP: begin
          if (key_s) begin
            state_d = ST_CHK_DN;
            cnt_d   = '0;
          end
        end

        ST_CHK_DN: begin
          if (!key_s) begin
            state_d = ST_UP;
            cnt_d   = '0;
          end else if (cnt_q == c_DEB_LAST) begin
            state_d = ST_DOWN;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
            rpt_d   = '0;
            first_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_DOWN: begin
          if (!key_s) begin
            state_d = ST_CHK_UP;
            cnt_d   = '0;
          end
          // Repeat timing advances on every edge spent in DOWN, including the one leaving it.
          if (c_RPT_EN) begin
            if (rpt_q == rpt_thr_last) begin
              repeat_d = 1'b1;
              rpt_d    = '0;
              first_d  = 1'b0;
            end else begin
              rpt_d = rpt_q + 1'b1;
            end
          end
        end

        ST_CHK_UP: begin
          if (key_s) begin
            state_d = ST_DOWN;
            cnt_d   = '0;
          end else if (cnt_q == c_DEB_LAST) begin
            state_d   = ST_UP;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = ST_UP;
          cnt_d   = '0;
        end
      endcase
    end

    assign keys_level[k]   = level_q;
    assign keys_press[k]   = press_q;
    assign keys_release[k] = release_q;
    assign keys_repeat[k]  = repeat_q;
  end : g_key

  assign keys_any = |keys_level;

endmodule

`default_nettype wire

// File: tb/tb_keys_debounce.sv
// ----------------------------------------------------------------------------
// tb_keys_debounce : directed scoreboard bench for keys_debounce
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_keys_debounce;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_REPEAT  = 2;
  // Raw change driven after edge n is first sampled at n+1 and accepted at n+1+DEB_CYCLES+2.
  localparam int LAT       = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] keys_in;
  logic [3:0] keys_level;
  logic [3:0] keys_press;
  logic [3:0] keys_release;
  logic [3:0] keys_repeat;
  logic       keys_any;

  keys_debounce #(
    .N_KEYS       (4),
    .ACTIVE_LOW   (1),
    .DEB_CYCLES   (4),
    .CNT_W        (16),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3),
    .RPT_W        (24)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .keys_in     (keys_in),
    .keys_level  (keys_level),
    .keys_press  (keys_press),
    .keys_release(keys_release),
    .keys_repeat (keys_repeat),
    .keys_any    (keys_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int key;
    int kind;
  } ev_t;

  ev_t        sb[$];
  int         cyc       = 0;
  int         n_assert  = 0;
  int         n_fail    = 0;
  logic [3:0] exp_level = 4'h0;

  task automatic push(input int key, input int kind, input int at);
    ev_t e;
    e.cyc  = at;
    e.key  = key;
    e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic check_outputs();
    logic [3:0] ep;
    logic [3:0] er;
    logic [3:0] et;
    ep = 4'h0;
    er = 4'h0;
    et = 4'h0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        if (sb[i].cyc < cyc) begin
          n_assert++;
          n_fail++;
          $error("FAIL stale_event key=%0d kind=%0d due=%0d now=%0d", sb[i].key, sb[i].kind, sb[i].cyc, cyc);
        end else begin
          case (sb[i].kind)
            K_PRESS:   ep[sb[i].key] = 1'b1;
            K_RELEASE: er[sb[i].key] = 1'b1;
            default:   et[sb[i].key] = 1'b1;
          endcase
        end
        sb.delete(i);
      end
    end
    exp_level = (exp_level | ep) & ~er;

    n_assert++;
    assert (keys_press === ep) else begin
      n_fail++;
      $error("FAIL press cyc=%0d observed=%b expected=%b", cyc, keys_press, ep);
    end
    n_assert++;
    assert (keys_release === er) else begin
      n_fail++;
      $error("FAIL release cyc=%0d observed=%b expected=%b", cyc, keys_release, er);
    end
    n_assert++;
    assert (keys_repeat === et) else begin
      n_fail++;
      $error("FAIL repeat cyc=%0d observed=%b expected=%b", cyc, keys_repeat, et);
    end
    n_assert++;
    assert (keys_level === exp_level) else begin
      n_fail++;
      $error("FAIL level cyc=%0d observed=%b expected=%b", cyc, keys_level, exp_level);
    end
    n_assert++;
    assert (keys_any === (|exp_level)) else begin
      n_fail++;
      $error("FAIL any cyc=%0d observed=%b expected=%b", cyc, keys_any, |exp_level);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
      check_outputs();
    end
  endtask

  int p;

  initial begin
    // Step 1: reset with all keys released, then 20 idle cycles.
    reset   = 1'b1;
    keys_in = 4'hF;
    tick(3);
    reset = 1'b0;
    tick(20);

    // Step 2: simple press and release of key 0.
    keys_in[0] = 1'b0;
    push(0, K_PRESS, cyc + LAT);
    tick(10);
    keys_in[0] = 1'b1;
    push(0, K_RELEASE, cyc + LAT);
    tick(12);

    // Step 3: bounce on key 1 never reaches the debounce count, then a clean press.
    keys_in[1] = 1'b0;
    tick(3);
    keys_in[1] = 1'b1;
    tick(1);
    keys_in[1] = 1'b0;
    tick(3);
    keys_in[1] = 1'b1;
    tick(8);
    keys_in[1] = 1'b0;
    push(1, K_PRESS, cyc + LAT);
    tick(10);
    keys_in[1] = 1'b1;
    push(1, K_RELEASE, cyc + LAT);
    tick(12);

    // Step 4: key 2 held long enough for three repeats, released before a fourth.
    keys_in[2] = 1'b0;
    p = cyc + LAT;
    push(2, K_PRESS, p);
    push(2, K_REPEAT, p + 10);
    push(2, K_REPEAT, p + 13);
    push(2, K_REPEAT, p + 16);
    tick(p + 14 - cyc);
    keys_in[2] = 1'b1;
    push(2, K_RELEASE, cyc + LAT);
    tick(15);

    // Step 5: keys 0 and 3 together; 2-cycle release glitch on key 3.
    // Key 3 sees s=0 on edges p+14 and p+15; p+15 and p+16 are spent in CHK_UP,
    // so its repeat due at p+16 slips to p+18.
    keys_in[0] = 1'b0;
    keys_in[3] = 1'b0;
    p = cyc + LAT;
    push(0, K_PRESS, p);
    push(3, K_PRESS, p);
    push(0, K_REPEAT, p + 10);
    push(0, K_REPEAT, p + 13);
    push(0, K_REPEAT, p + 16);
    push(0, K_REPEAT, p + 19);
    push(3, K_REPEAT, p + 10);
    push(3, K_REPEAT, p + 13);
    push(3, K_REPEAT, p + 18);
    tick(p + 11 - cyc);
    keys_in[3] = 1'b1;
    tick(2);
    keys_in[3] = 1'b0;
    tick(p + 20 - cyc);

    // Step 6: asynchronous reset while key 0 is held.
    keys_in[3] = 1'b1;
    reset      = 1'b1;
    #1;
    n_assert++;
    assert (keys_level === 4'h0) else begin
      n_fail++;
      $error("FAIL async_reset_level observed=%b expected=%b", keys_level, 4'h0);
    end
    n_assert++;
    assert (keys_any === 1'b0) else begin
      n_fail++;
      $error("FAIL async_reset_any observed=%b expected=%b", keys_any, 1'b0);
    end
    n_assert++;
    assert (keys_release === 4'h0) else begin
      n_fail++;
      $error("FAIL async_reset_release observed=%b expected=%b", keys_release, 4'h0);
    end
    exp_level = 4'h0;
    tick(3);
    reset = 1'b0;
    push(0, K_PRESS, cyc + LAT);
    tick(12);

    n_assert++;
    assert (sb.size() === 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=%0d", sb.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
